serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/sub_digit.sv | 19 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 32;
  localparam int SUB_DIGIT_DEFAULT = 4;

  // Number of RUN cycles needed to cover the whole operand.
  function automatic int nslices(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-bit slice of subtract-with-borrow, done as a + ~b + ~bin.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] sum;

  // A carry out of the slice means no borrow was needed.
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, ~bin};
  assign d    = sum[DIGIT-1:0];
  assign bout = ~sum[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - b_in with valid/ready handshakes on both sides.
// Optional zero-result flag enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT,
  parameter int DIGIT = SUB_DIGIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             overflow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int N  = nslices(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  sub_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, diff_reg, diff_next;
  logic [CW-1:0]    cnt_reg;
  logic             borrow_reg, b_out_reg, overflow_reg;
  logic             a_msb_reg, b_msb_reg;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bout;
  logic             cnt_last;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a    (a_reg[DIGIT-1:0]),
    .b    (b_reg[DIGIT-1:0]),
    .bin  (borrow_reg),
    .d    (slice_d),
    .bout (slice_bout)
  );

  assign cnt_last  = (cnt_reg == CW'(N - 1));
  // New slice enters at the top so the LSB slice ends up at the bottom after N shifts.
  assign diff_next = (diff_reg >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (cnt_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      diff_reg     <= '0;
      cnt_reg      <= '0;
      borrow_reg   <= 1'b0;
      b_out_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= b_in;
            cnt_reg    <= '0;
            a_msb_reg  <= A[WIDTH-1];
            b_msb_reg  <= B[WIDTH-1];
          end
        end
        RUN: begin
          a_reg      <= a_reg >> DIGIT;
          b_reg      <= b_reg >> DIGIT;
          borrow_reg <= slice_bout;
          diff_reg   <= diff_next;
          cnt_reg    <= cnt_last ? '0 : cnt_reg + 1'b1;
          if (cnt_last) begin
            // The last slice's top bit is the final result's sign bit.
            b_out_reg    <= slice_bout;
            overflow_reg <= (a_msb_reg != b_msb_reg) && (slice_d[DIGIT-1] != a_msb_reg);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      zero_reg <= 1'b1;
    end else if (state_reg == RUN) begin
      zero_reg <= zero_reg & (slice_d == '0);
    end
  end

  assign zero = zero_reg;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign b_out     = b_out_reg;
  assign overflow  = overflow_reg;

endmodule
